wt_dcache_rd_arbiter: RTL and testbench

Arbitrates the read ports of the write-through L1 data cache (load unit, PTW, write buffer) onto the single tag/data read port of the cache memory arrays. Applies two priority classes: high-priority ports share round-robin, low-priority ports are served when idle or when a starvation counter expires. Cacheline refills/invalidations from the miss unit pre-empt all reads. Also registers the winner's tag and port so the next-stage tag compare and data return can be steered.

---
 rtl/wt_cache_pkg.sv | 15 +
 rtl/wt_dcache_rr_pick.sv | 35 +++
 rtl/wt_dcache_rd_arbiter.sv | 144 ++++++++++++++
 tb/tb_wt_dcache_rd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared write-through cache geometry constants.
// Read-port arbitration defaults live alongside the array sizes.
package wt_cache_pkg;

    localparam int unsigned DCACHE_TAG_WIDTH       = 20;
    localparam int unsigned DCACHE_CL_IDX_WIDTH    = 8;
    localparam int unsigned DCACHE_OFFSET_WIDTH    = 4;
    localparam int unsigned DCACHE_RD_PORTS        = 3;
    localparam int unsigned DCACHE_RD_STARVE_LIMIT = 8;

    function automatic int unsigned ptr_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// N-way round-robin picker: search starts one past the pointer and wraps.
// Returns a one-hot grant plus the binary index of the winner.
module wt_dcache_rr_pick
    import wt_cache_pkg::*;
#(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = ptr_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    int w_j;

    // Walk farthest-to-nearest so the nearest requester overwrites last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_j   = 0;
        for (int k = int'(N); k >= 1; k--) begin
            w_j = (int'(i_ptr) + k) % int'(N);
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
                o_vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wt_dcache_rd_arbiter.sv
// Read-port arbiter for the write-through L1 D$ tag/data arrays.
// High class round-robins; low class is served when idle or starving.
module wt_dcache_rd_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts    = DCACHE_RD_PORTS,
    parameter int unsigned StarveLimit = DCACHE_RD_STARVE_LIMIT,
    parameter int unsigned TagWidth    = DCACHE_TAG_WIDTH,
    parameter int unsigned IdxWidth    = DCACHE_CL_IDX_WIDTH,
    parameter int unsigned OffWidth    = DCACHE_OFFSET_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumPorts-1:0]          rd_req_i,
    input  logic [NumPorts-1:0]          rd_prio_i,
    input  logic [NumPorts-1:0]          rd_tag_only_i,
    input  logic [NumPorts*TagWidth-1:0] rd_tag_i,
    input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
    input  logic [NumPorts*OffWidth-1:0] rd_off_i,
    output logic [NumPorts-1:0]          rd_ack_o,
    input  logic                         wr_cl_vld_i,
    output logic                         mem_rd_en_o,
    output logic [IdxWidth-1:0]          mem_rd_idx_o,
    output logic [OffWidth-1:0]          mem_rd_off_o,
    output logic                         mem_rd_tag_only_o,
    output logic                         cmp_vld_o,
    output logic [TagWidth-1:0]          cmp_tag_o,
    output logic [NumPorts-1:0]          cmp_port_o,
    output logic                         starve_o
);

    localparam int unsigned PW = ptr_width(NumPorts);
    localparam int unsigned CW = $clog2(StarveLimit + 1);
    localparam logic [CW-1:0] CntMax = CW'(StarveLimit);

    logic [PW-1:0]       r_hi_ptr;
    logic [CW-1:0]       r_cnt;
    logic                r_cmp_vld;
    logic [TagWidth-1:0] r_cmp_tag;
    logic [NumPorts-1:0] r_cmp_port;

    logic [NumPorts-1:0] w_hi;
    logic [NumPorts-1:0] w_lo;
    logic [NumPorts-1:0] w_hi_gnt;
    logic [PW-1:0]       w_hi_idx;
    logic                w_hi_vld;
    logic [NumPorts-1:0] w_lo_gnt;
    logic [PW-1:0]       w_lo_idx;
    logic                w_lo_any;
    logic                w_force;
    logic [NumPorts-1:0] w_ack;
    logic [PW-1:0]       w_sel;
    logic                w_hi_win;
    logic                w_lo_win;
    logic                w_en;
    logic [TagWidth-1:0] w_tag;

    assign w_hi     = rd_req_i & rd_prio_i;
    assign w_lo     = rd_req_i & ~rd_prio_i;
    assign w_lo_any = |w_lo;
    assign w_force  = (r_cnt == CntMax) && w_lo_any;

    wt_dcache_rr_pick #(
        .N (NumPorts)
    ) u_hi_pick (
        .i_req (w_hi),
        .i_ptr (r_hi_ptr),
        .o_gnt (w_hi_gnt),
        .o_idx (w_hi_idx),
        .o_vld (w_hi_vld)
    );

    always_comb begin
        w_lo_gnt = '0;
        w_lo_idx = '0;
        for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
            if (w_lo[i]) begin
                w_lo_gnt    = '0;
                w_lo_gnt[i] = 1'b1;
                w_lo_idx    = PW'(i);
            end
        end
    end

    always_comb begin
        w_ack    = '0;
        w_sel    = '0;
        w_hi_win = 1'b0;
        w_lo_win = 1'b0;
        if (!wr_cl_vld_i) begin
            if (w_force || (!w_hi_vld && w_lo_any)) begin
                w_ack    = w_lo_gnt;
                w_sel    = w_lo_idx;
                w_lo_win = 1'b1;
            end else if (w_hi_vld) begin
                w_ack    = w_hi_gnt;
                w_sel    = w_hi_idx;
                w_hi_win = 1'b1;
            end
        end
    end

    // Outputs are gated so an idle cycle presents all-zero fields.
    assign w_en  = |w_ack;
    assign w_tag = rd_tag_i[w_sel*TagWidth +: TagWidth];

    assign rd_ack_o          = w_ack;
    assign mem_rd_en_o       = w_en;
    assign mem_rd_idx_o      = w_en ? rd_idx_i[w_sel*IdxWidth +: IdxWidth] : '0;
    assign mem_rd_off_o      = w_en ? rd_off_i[w_sel*OffWidth +: OffWidth] : '0;
    assign mem_rd_tag_only_o = w_en & rd_tag_only_i[w_sel];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hi_ptr   <= PW'(NumPorts - 1);
            r_cnt      <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_tag  <= '0;
            r_cmp_port <= '0;
        end else begin
            if (w_hi_win) begin
                r_hi_ptr <= w_sel;
            end
            if (w_lo_any && !w_lo_win) begin
                if (r_cnt != CntMax) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_cmp_vld  <= w_en;
            r_cmp_port <= w_ack;
            if (w_en) begin
                r_cmp_tag <= w_tag;
            end
        end
    end

    assign cmp_vld_o  = r_cmp_vld;
    assign cmp_tag_o  = r_cmp_tag;
    assign cmp_port_o = r_cmp_port;
    assign starve_o   = (r_cnt == CntMax);

endmodule

// File: tb/tb_wt_dcache_rd_arbiter.sv
// Scoreboard bench for the D$ read-port arbiter.
// Grants are checked in-cycle; the expected cmp_* bundle is queued.
module tb_wt_dcache_rd_arbiter;
    import wt_cache_pkg::*;

    localparam int TW = DCACHE_TAG_WIDTH;
    localparam int XW = DCACHE_CL_IDX_WIDTH;
    localparam int OW = DCACHE_OFFSET_WIDTH;

    typedef struct packed {
        logic          vld;
        logic [2:0]    port;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [2:0]    rd_req_i = '0;
    logic [2:0]    rd_prio_i = '0;
    logic [2:0]    rd_tag_only_i = '0;
    logic          wr_cl_vld_i = 1'b0;
    logic [TW-1:0] tags [3];
    logic [XW-1:0] idxs [3];
    logic [OW-1:0] offs [3];

    logic [2:0]    rd_ack_o;
    logic          mem_rd_en_o;
    logic [XW-1:0] mem_rd_idx_o;
    logic [OW-1:0] mem_rd_off_o;
    logic          mem_rd_tag_only_o;
    logic          cmp_vld_o;
    logic [TW-1:0] cmp_tag_o;
    logic [2:0]    cmp_port_o;
    logic          starve_o;

    int   vectors = 0;
    int   errors  = 0;
    exp_t sb [$];
    exp_t e;

    always #5 clk_i = ~clk_i;

    wt_dcache_rd_arbiter #(
        .NumPorts    (3),
        .StarveLimit (8)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .rd_req_i          (rd_req_i),
        .rd_prio_i         (rd_prio_i),
        .rd_tag_only_i     (rd_tag_only_i),
        .rd_tag_i          ({tags[2], tags[1], tags[0]}),
        .rd_idx_i          ({idxs[2], idxs[1], idxs[0]}),
        .rd_off_i          ({offs[2], offs[1], offs[0]}),
        .rd_ack_o          (rd_ack_o),
        .wr_cl_vld_i       (wr_cl_vld_i),
        .mem_rd_en_o       (mem_rd_en_o),
        .mem_rd_idx_o      (mem_rd_idx_o),
        .mem_rd_off_o      (mem_rd_off_o),
        .mem_rd_tag_only_o (mem_rd_tag_only_o),
        .cmp_vld_o         (cmp_vld_o),
        .cmp_tag_o         (cmp_tag_o),
        .cmp_port_o        (cmp_port_o),
        .starve_o          (starve_o)
    );

    function automatic exp_t mk(logic [2:0] ack, logic rst);
        exp_t r;
        r.vld  = (|ack) && !rst;
        r.port = rst ? 3'b000 : ack;
        r.tag  = '0;
        for (int p = 0; p < 3; p++) if (ack[p]) r.tag = tags[p];
        return r;
    endfunction

    function automatic logic [XW-1:0] exp_idx(logic [2:0] ack);
        logic [XW-1:0] r;
        r = '0;
        for (int p = 0; p < 3; p++) if (ack[p]) r = idxs[p];
        return r;
    endfunction

    task automatic set_fields();
        for (int p = 0; p < 3; p++) begin
            tags[p] = TW'(32'h100 + 32'h11 * p);
            idxs[p] = XW'(8'h10 + p);
            offs[p] = OW'(p + 1);
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        rd_req_i = '0;
        rd_prio_i = '0;
        rd_tag_only_i = '0;
        wr_cl_vld_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if (cmp_vld_o !== 1'b0) begin
            errors++; $display("FAIL reset_cmp_vld: got %b want 0", cmp_vld_o);
        end
        vectors++;
        if (cmp_tag_o !== '0) begin
            errors++; $display("FAIL reset_cmp_tag: got %h want 0", cmp_tag_o);
        end
        vectors++;
        if (cmp_port_o !== 3'b000) begin
            errors++; $display("FAIL reset_cmp_port: got %b want 000", cmp_port_o);
        end
        vectors++;
        if (starve_o !== 1'b0) begin
            errors++; $display("FAIL reset_starve: got %b want 0", starve_o);
        end
        vectors++;
        if (rd_ack_o !== 3'b000 || mem_rd_en_o !== 1'b0 || mem_rd_idx_o !== '0) begin
            errors++;
            $display("FAIL reset_idle: ack=%b en=%b idx=%h want 000/0/00",
                     rd_ack_o, mem_rd_en_o, mem_rd_idx_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_round_robin();
        logic [2:0] ak [6] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            rd_req_i = 3'b011; rd_prio_i = 3'b011;
            #1;
            vectors++;
            if (rd_ack_o !== ak[i] || starve_o !== 1'b0 || mem_rd_en_o !== 1'b1 ||
                mem_rd_idx_o !== exp_idx(ak[i])) begin
                errors++;
                $display("FAIL rr c%0d: ack=%b st=%b idx=%h want ack=%b st=0 idx=%h",
                         i, rd_ack_o, starve_o, mem_rd_idx_o, ak[i], exp_idx(ak[i]));
            end
            sb.push_back(mk(ak[i], 1'b0));
            @(posedge clk_i); #1;
            e = sb.pop_front(); vectors++;
            if (cmp_vld_o !== e.vld || cmp_port_o !== e.port || (e.vld && cmp_tag_o !== e.tag)) begin
                errors++;
                $display("FAIL rr_cmp c%0d: vld=%b port=%b tag=%h want %b %b %h",
                         i, cmp_vld_o, cmp_port_o, cmp_tag_o, e.vld, e.port, e.tag);
            end
        end
    endtask

    task automatic test_starvation();
        logic [2:0] ak [11];
        logic       sv [11];
        for (int i = 0; i < 11; i++) begin
            ak[i] = (i == 8) ? 3'b100 : 3'b001;
            sv[i] = (i == 8);
        end
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            rd_req_i = 3'b101; rd_prio_i = 3'b001;
            #1;
            vectors++;
            if (rd_ack_o !== ak[i] || starve_o !== sv[i] || mem_rd_en_o !== 1'b1 ||
                mem_rd_off_o !== offs[(i == 8) ? 2 : 0]) begin
                errors++;
                $display("FAIL starve c%0d: ack=%b st=%b off=%h want ack=%b st=%b",
                         i, rd_ack_o, starve_o, mem_rd_off_o, ak[i], sv[i]);
            end
            sb.push_back(mk(ak[i], 1'b0));
            @(posedge clk_i); #1;
            e = sb.pop_front(); vectors++;
            if (cmp_vld_o !== e.vld || cmp_port_o !== e.port || (e.vld && cmp_tag_o !== e.tag)) begin
                errors++;
                $display("FAIL starve_cmp c%0d: vld=%b port=%b tag=%h want %b %b %h",
                         i, cmp_vld_o, cmp_port_o, cmp_tag_o, e.vld, e.port, e.tag);
            end
        end
    endtask

    task automatic test_wr_block();
        logic       wt [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        logic [2:0] ak [10] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010,
                                3'b001, 3'b010, 3'b001, 3'b100, 3'b010};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            rd_req_i = 3'b111; rd_prio_i = 3'b011; wr_cl_vld_i = wt[i];
            #1;
            vectors++;
            if (rd_ack_o !== ak[i] || starve_o !== (i == 8) || mem_rd_en_o !== (|ak[i]) ||
                mem_rd_idx_o !== exp_idx(ak[i])) begin
                errors++;
                $display("FAIL wrblk c%0d: ack=%b st=%b en=%b want ack=%b st=%b",
                         i, rd_ack_o, starve_o, mem_rd_en_o, ak[i], (i == 8));
            end
            sb.push_back(mk(ak[i], 1'b0));
            @(posedge clk_i); #1;
            e = sb.pop_front(); vectors++;
            if (cmp_vld_o !== e.vld || cmp_port_o !== e.port || (e.vld && cmp_tag_o !== e.tag)) begin
                errors++;
                $display("FAIL wrblk_cmp c%0d: vld=%b port=%b tag=%h want %b %b %h",
                         i, cmp_vld_o, cmp_port_o, cmp_tag_o, e.vld, e.port, e.tag);
            end
        end
        wr_cl_vld_i = 1'b0;
    endtask

    task automatic test_tag_only();
        logic [2:0] rq [2] = '{3'b010, 3'b000};
        logic [2:0] ak [2] = '{3'b010, 3'b000};
        apply_reset();
        tags[1] = TW'(32'h1F3);
        idxs[1] = XW'(8'h2A);
        for (int i = 0; i < 2; i++) begin
            rd_req_i = rq[i]; rd_prio_i = 3'b000; rd_tag_only_i = 3'b010;
            #1;
            vectors++;
            if (rd_ack_o !== ak[i] || mem_rd_en_o !== (|ak[i]) ||
                mem_rd_idx_o !== ((i == 0) ? XW'(8'h2A) : XW'(0)) ||
                mem_rd_tag_only_o !== (i == 0)) begin
                errors++;
                $display("FAIL tagonly c%0d: ack=%b idx=%h to=%b want ack=%b",
                         i, rd_ack_o, mem_rd_idx_o, mem_rd_tag_only_o, ak[i]);
            end
            sb.push_back(mk(ak[i], 1'b0));
            @(posedge clk_i); #1;
            e = sb.pop_front(); vectors++;
            if (cmp_vld_o !== e.vld || cmp_port_o !== e.port || (e.vld && cmp_tag_o !== e.tag)) begin
                errors++;
                $display("FAIL tagonly_cmp c%0d: vld=%b port=%b tag=%h want %b %b %h",
                         i, cmp_vld_o, cmp_port_o, cmp_tag_o, e.vld, e.port, e.tag);
            end
        end
        rd_tag_only_i = '0;
        set_fields();
    endtask

    task automatic test_prio_toggle();
        logic [2:0] rq [4] = '{3'b111, 3'b111, 3'b101, 3'b111};
        logic [2:0] pr [4] = '{3'b011, 3'b011, 3'b000, 3'b011};
        logic [2:0] ak [4] = '{3'b001, 3'b010, 3'b001, 3'b001};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            rd_req_i = rq[i]; rd_prio_i = pr[i];
            #1;
            vectors++;
            if (rd_ack_o !== ak[i] || starve_o !== 1'b0 || mem_rd_idx_o !== exp_idx(ak[i])) begin
                errors++;
                $display("FAIL prio c%0d: ack=%b st=%b want ack=%b st=0",
                         i, rd_ack_o, starve_o, ak[i]);
            end
            sb.push_back(mk(ak[i], 1'b0));
            @(posedge clk_i); #1;
            e = sb.pop_front(); vectors++;
            if (cmp_vld_o !== e.vld || cmp_port_o !== e.port || (e.vld && cmp_tag_o !== e.tag)) begin
                errors++;
                $display("FAIL prio_cmp c%0d: vld=%b port=%b tag=%h want %b %b %h",
                         i, cmp_vld_o, cmp_port_o, cmp_tag_o, e.vld, e.port, e.tag);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       rt [6] = '{0, 0, 0, 1, 0, 0};
        logic [2:0] ak [6] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            rd_req_i = 3'b011; rd_prio_i = 3'b011; rst_i = rt[i];
            #1;
            vectors++;
            if (rd_ack_o !== ak[i] || mem_rd_en_o !== 1'b1) begin
                errors++;
                $display("FAIL rstmid c%0d: ack=%b en=%b want ack=%b en=1",
                         i, rd_ack_o, mem_rd_en_o, ak[i]);
            end
            sb.push_back(mk(ak[i], rt[i]));
            @(posedge clk_i); #1;
            e = sb.pop_front(); vectors++;
            if (cmp_vld_o !== e.vld || cmp_port_o !== e.port || (e.vld && cmp_tag_o !== e.tag)) begin
                errors++;
                $display("FAIL rstmid_cmp c%0d: vld=%b port=%b tag=%h want %b %b %h",
                         i, cmp_vld_o, cmp_port_o, cmp_tag_o, e.vld, e.port, e.tag);
            end
        end
        rst_i = 1'b0;
        rd_req_i = '0;
    endtask

    initial begin
        set_fields();
        test_reset();
        test_round_robin();
        test_starvation();
        test_wr_block();
        test_tag_only();
        test_prio_toggle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
